// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package nsa_pkg;

   localparam int unsigned NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

endpackage

// File: rtl/fulladd4.sv
// 4-bit adder slice: the shared datapath reused once per nibble by the controller.
module fulladd4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c_in,
   output logic [3:0] sum,
   output logic       c_out
);

   // Plain 4-bit add with carry-in; carry-out is the fifth result bit.
   always_comb begin
      {c_out, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};
   end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder sequencer: adds WIDTH-bit operands one nibble per clock
// through a single fulladd4 slice, LSB nibble first, carry registered between
// nibbles. Valid/ready handshakes on operand accept and result return.
// Optional macro NSA_OVERFLOW_EN adds a registered signed-overflow output ovf.
module nibble_serial_add_ctrl
   import nsa_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
`ifdef NSA_OVERFLOW_EN
   output logic             ovf,
`endif
   output logic             busy
);

   localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
   localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t              state;
   logic [WIDTH-1:0]    a_r;
   logic [WIDTH-1:0]    b_r;
   logic                carry_r;
   logic [IDX_W-1:0]    idx;

   logic [NIBBLE_W-1:0] slice_a;
   logic [NIBBLE_W-1:0] slice_b;
   logic [NIBBLE_W-1:0] slice_sum;
   logic                slice_cout;

   // Select the current nibble of each captured operand for the shared slice.
   always_comb begin
      slice_a = a_r[NIBBLE_W*idx +: NIBBLE_W];
      slice_b = b_r[NIBBLE_W*idx +: NIBBLE_W];
   end

   fulladd4 u_slice (
      .a     (slice_a),
      .b     (slice_b),
      .c_in  (carry_r),
      .sum   (slice_sum),
      .c_out (slice_cout)
   );

   // Control FSM with registered handshake outputs and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         sum       <= '0;
         c_out     <= 1'b0;
         a_r       <= '0;
         b_r       <= '0;
         carry_r   <= 1'b0;
         idx       <= '0;
`ifdef NSA_OVERFLOW_EN
         ovf       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_r      <= a;
                  b_r      <= b;
                  carry_r  <= c_in;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               sum[NIBBLE_W*idx +: NIBBLE_W] <= slice_sum;
               carry_r <= slice_cout;
               idx     <= idx + 1'b1;
               if (idx == LAST_IDX) begin
                  c_out     <= slice_cout;
                  out_valid <= 1'b1;
                  state     <= DONE;
`ifdef NSA_OVERFLOW_EN
                  ovf <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                         (slice_sum[NIBBLE_W-1] != a_r[WIDTH-1]);
`endif
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
